iob_gray_updown_counter: RTL and testbench
==========================================

Name: iob_gray_updown_counter

Overview:
- Parametrised up/down Gray-code counter; next generation of the single-direction Gray counter.
- Adds direction control, synchronous load, optional saturation, a registered wrap pulse and terminal-count flags.
- bin_o and gray_o always describe the same count in the same cycle.
- gray_nxt_o gives one-cycle lookahead, for async-FIFO pointers and CDC-safe position counters.

Parameters:
- W, 4, counter width in bits; legal range 1..32. Modulus is 2^W.
- RST_VAL, 0, binary count loaded on reset; W bits.
- SATURATE, 0, 0 = wrap modulo 2^W; 1 = hold at the extremes, no wrap.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- en_i  input  1  count enable.
- dir_i  input  1  direction: 1 = up (+1), 0 = down (-1); sampled only when en_i=1.
- ld_i  input  1  synchronous load strobe.
- ld_val_i  input  W  binary value to load.
- bin_o  output  W  current count, binary, registered.
- gray_o  output  W  current count, Gray, registered.
- gray_nxt_o  output  W  Gray of the value the counter takes at the next edge; combinational.
- wrap_o  output  1  one-cycle pulse, registered.
- max_o  output  1  bin_o == 2^W-1.
- min_o  output  1  bin_o == 0.

Behaviour:
- Reset: when rst_i=1 at an edge, all outputs take these values at the next edge:
  - bin_o = RST_VAL
  - gray_o = RST_VAL ^ (RST_VAL>>1)
  - wrap_o = 0
  - max_o / min_o follow from RST_VAL.
  - Reset mid-count overrides en_i and ld_i in that cycle.
- Priority per edge: rst_i > ld_i > en_i > hold.
- Load (ld_i=1):
  - bin_o = ld_val_i and gray_o = its Gray encoding at the next edge; latency 1.
  - wrap_o = 0. en_i and dir_i are ignored that cycle.
- Count (en_i=1, ld_i=0):
  - Up: bin +1 modulo 2^W. Down: bin -1 modulo 2^W.
  - The change in gray_o is exactly one bit per step. This is the key invariant and must hold across wrap-around.
- Wrap, SATURATE=0:
  - Up from 2^W-1 to 0, or down from 0 to 2^W-1.
  - wrap_o=1 in the cycle the new value appears, for exactly one cycle.
  - Consecutive wraps are each pulsed; W=1 counting continuously gives wrap_o=1 every other cycle.
- Saturation, SATURATE=1:
  - Up at 2^W-1, or down at 0, leaves the state unchanged.
  - gray_nxt_o equals gray_o in that case; wrap_o stays 0.
- Idle (en_i=0, ld_i=0, rst_i=0): state held; wrap_o=0.
- Encoding:
  - gray = bin ^ (bin>>1).
  - Both registers are updated from the same next-state binary value, so gray_o never lags bin_o.
- gray_nxt_o:
  - Is the Gray encoding of the next-state mux output, including the rst_i, ld_i and saturate branches.
  - Only valid for downstream registering; not glitch-free.
- max_o / min_o: decoded from the bin register; same cycle as bin_o.
- W=1: gray equals bin; max_o = bin_o; min_o = ~bin_o.
- Both registers are always enabled; there is no cke.

Test Plan:
- Reset and up-count, W=4, RST_VAL=0, SATURATE=0:
  - Stimulus: rst_i=1 for 1 cycle, then en_i=1, dir_i=1 for 17 cycles.
  - Response: gray_o sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap_o=1 only in the cycle bin_o returns to 0.
  - A monitor checks Hamming distance 1 on every gray_o change.
- Down-count wrap:
  - Stimulus: from bin_o=1, en_i=1, dir_i=0 for 3 cycles.
  - Response: bin_o 0, F, E; gray_o 0, 8, 9.
  - wrap_o pulses on the 0 to F step.
  - min_o=1 at bin 0; max_o=1 at F.
- Load priority:
  - Stimulus: ld_i=1, ld_val_i=A, en_i=1 in the same cycle.
  - Response: next bin_o=A, gray_o=F, wrap_o=0.
  - Same cycle with rst_i=1 added: next bin_o=RST_VAL.
- Saturate, SATURATE=1:
  - Stimulus: load F, then en_i=1, dir_i=1 for 3 cycles.
  - Response: bin_o stays F, gray_nxt_o == gray_o == 8, wrap_o stays 0.
  - Then dir_i=0 for 16 cycles: bin_o stops at 0 and holds.
- Lookahead and hold:
  - Random en_i, dir_i, ld_i over 10k cycles, W=5, RST_VAL=7.
  - Every cycle: gray_o equals the previous cycle's gray_nxt_o, and gray_o == bin_o ^ (bin_o>>1).
  - en_i=0 cycles hold state.
- W=1:
  - Stimulus: continuous en_i=1, dir_i=1.
  - Response: bin_o and gray_o toggle 0,1,0,1; wrap_o=1 on each 1 to 0 step.

Source files
------------

// File: rtl/iob_gray_updown_counter.sv
// Up/down Gray-code counter with synchronous load, optional saturation,
// a registered wrap pulse, terminal-count flags and one-cycle Gray lookahead.
module iob_gray_updown_counter #(
  parameter int unsigned    W        = 4,
  parameter logic [W-1:0]   RST_VAL  = '0,
  parameter int unsigned    SATURATE = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] bin_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] gray_nxt_o,
  output logic         wrap_o,
  output logic         max_o,
  output logic         min_o
);

  localparam logic         SAT     = (SATURATE != 0);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] bin_nxt;
  logic         wrap_nxt;

  // Single next-state mux feeds both registers and the lookahead, so the
  // binary and Gray views can never disagree.
  always_comb begin
    bin_nxt  = bin_o;
    wrap_nxt = 1'b0;
    if (rst_i) begin
      bin_nxt = RST_VAL;
    end else if (ld_i) begin
      bin_nxt = ld_val_i;
    end else if (en_i) begin
      if (dir_i) begin
        if (bin_o == CNT_MAX) begin
          if (!SAT) begin
            bin_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_o + W'(1);
        end
      end else begin
        if (bin_o == '0) begin
          if (!SAT) begin
            bin_nxt  = CNT_MAX;
            wrap_nxt = 1'b1;
          end
        end else begin
          bin_nxt = bin_o - W'(1);
        end
      end
    end
  end

  assign gray_nxt_o = bin_nxt ^ (bin_nxt >> 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_o  <= RST_VAL;
      gray_o <= RST_VAL ^ (RST_VAL >> 1);
      wrap_o <= 1'b0;
    end else begin
      bin_o  <= bin_nxt;
      gray_o <= gray_nxt_o;
      wrap_o <= wrap_nxt;
    end
  end

  assign max_o = &bin_o;
  assign min_o = ~|bin_o;

endmodule

// File: tb/tb_iob_gray_updown_counter.sv
// Scoreboard bench: four counter configurations share one randomized stimulus
// stream and are checked against an arithmetic modulo/saturation model.
module tb_iob_gray_updown_counter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, en_i = 1'b0, dir_i = 1'b0, ld_i = 1'b0;
  logic [31:0] ld_val = '0;

  always #5 clk = ~clk;

  logic [3:0] b0, g0, n0;  logic w0, x0, z0;
  logic [3:0] b1, g1, n1;  logic w1, x1, z1;
  logic [4:0] b2, g2, n2;  logic w2, x2, z2;
  logic [0:0] b3, g3, n3;  logic w3, x3, z3;

  iob_gray_updown_counter #(.W(4), .RST_VAL(4'd0), .SATURATE(0)) u0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .ld_i(ld_i),
    .ld_val_i(ld_val[3:0]), .bin_o(b0), .gray_o(g0), .gray_nxt_o(n0),
    .wrap_o(w0), .max_o(x0), .min_o(z0));
  iob_gray_updown_counter #(.W(4), .RST_VAL(4'd3), .SATURATE(1)) u1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .ld_i(ld_i),
    .ld_val_i(ld_val[3:0]), .bin_o(b1), .gray_o(g1), .gray_nxt_o(n1),
    .wrap_o(w1), .max_o(x1), .min_o(z1));
  iob_gray_updown_counter #(.W(5), .RST_VAL(5'd7), .SATURATE(0)) u2 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .ld_i(ld_i),
    .ld_val_i(ld_val[4:0]), .bin_o(b2), .gray_o(g2), .gray_nxt_o(n2),
    .wrap_o(w2), .max_o(x2), .min_o(z2));
  iob_gray_updown_counter #(.W(1), .RST_VAL(1'b0), .SATURATE(0)) u3 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .ld_i(ld_i),
    .ld_val_i(ld_val[0:0]), .bin_o(b3), .gray_o(g3), .gray_nxt_o(n3),
    .wrap_o(w3), .max_o(x3), .min_o(z3));

  logic [31:0] dbin[4], dgray[4], dnxt[4];
  logic        dwrap[4], dmax[4], dmin[4];
  assign dbin[0] = 32'(b0); assign dgray[0] = 32'(g0); assign dnxt[0] = 32'(n0);
  assign dbin[1] = 32'(b1); assign dgray[1] = 32'(g1); assign dnxt[1] = 32'(n1);
  assign dbin[2] = 32'(b2); assign dgray[2] = 32'(g2); assign dnxt[2] = 32'(n2);
  assign dbin[3] = 32'(b3); assign dgray[3] = 32'(g3); assign dnxt[3] = 32'(n3);
  assign dwrap[0] = w0; assign dmax[0] = x0; assign dmin[0] = z0;
  assign dwrap[1] = w1; assign dmax[1] = x1; assign dmin[1] = z1;
  assign dwrap[2] = w2; assign dmax[2] = x2; assign dmin[2] = z2;
  assign dwrap[3] = w3; assign dmax[3] = x3; assign dmin[3] = z3;

  function automatic int unsigned pw(input int i);
    case (i) 0: return 4; 1: return 4; 2: return 5; default: return 1; endcase
  endfunction
  function automatic int unsigned prv(input int i);
    case (i) 1: return 3; 2: return 7; default: return 0; endcase
  endfunction
  function automatic logic psat(input int i);
    return (i == 1);
  endfunction

  typedef struct packed {
    logic [3:0][31:0] bin;
    logic [3:0][31:0] gray;
    logic [3:0]       wrap;
    logic [3:0]       mx;
    logic [3:0]       mn;
    logic [3:0]       cnt;
    logic             tab_v;
    logic [31:0]      tab;
  } exp_t;

  exp_t             sq[$];
  logic [3:0][31:0] nq[$];
  int unsigned      m[4];
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic d, input logic l,
                       input logic [31:0] v, input logic tv, input logic [31:0] tg);
    exp_t             x;
    logic [3:0][31:0] nx;
    @(negedge clk);
    rst_i = r; en_i = e; dir_i = d; ld_i = l; ld_val = v;
    #1;
    x = '0;
    nx = '0;
    x.tab_v = tv;
    x.tab   = tg;
    for (int i = 0; i < 4; i++) begin
      int unsigned mod, n;
      logic w;
      mod = 1 << pw(i);
      w = 1'b0;
      if (r) n = prv(i);
      else if (l) n = v % mod;
      else if (e) begin
        if (d) begin n = (m[i] + 1) % mod; w = (m[i] + 1 == mod); end
        else begin n = (m[i] + mod - 1) % mod; w = (m[i] == 0); end
        if (w && psat(i)) begin n = m[i]; w = 1'b0; end
      end else n = m[i];
      x.bin[i]  = n;
      x.gray[i] = n ^ (n >> 1);
      x.wrap[i] = w;
      x.mx[i]   = (n == mod - 1);
      x.mn[i]   = (n == 0);
      x.cnt[i]  = !r && !l;
      nx[i]     = n ^ (n >> 1);
      m[i]      = n;
    end
    sq.push_back(x);
    nq.push_back(nx);
  endtask

  // Lookahead monitor: gray_nxt_o must match the Gray of the coming state.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (nq.size() != 0) begin
        logic [3:0][31:0] nx;
        nx = nq.pop_front();
        for (int i = 0; i < 4; i++) chk($sformatf("u%0d gray_nxt", i), dnxt[i], nx[i]);
      end
    end
  end

  // Registered-output monitor with one-bit-change check on counting steps.
  initial begin
    logic [31:0] pg[4];
    logic        pv;
    pv = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sq.size() != 0) begin
        exp_t x;
        x = sq.pop_front();
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("u%0d bin", i),  dbin[i],  x.bin[i]);
          chk($sformatf("u%0d gray", i), dgray[i], x.gray[i]);
          chk($sformatf("u%0d wrap", i), 32'(dwrap[i]), 32'(x.wrap[i]));
          chk($sformatf("u%0d max", i),  32'(dmax[i]),  32'(x.mx[i]));
          chk($sformatf("u%0d min", i),  32'(dmin[i]),  32'(x.mn[i]));
          if (pv && x.cnt[i] && dgray[i] !== pg[i])
            chk($sformatf("u%0d hamming", i), 32'($countones(dgray[i] ^ pg[i])), 32'd1);
          pg[i] = dgray[i];
        end
        pv = 1'b1;
        if (x.tab_v) chk("u0 gray table", dgray[0], x.tab);
      end
    end
  end

  initial begin
    logic [31:0] tab[16];
    tab = '{32'h0, 32'h1, 32'h3, 32'h2, 32'h6, 32'h7, 32'h5, 32'h4,
            32'hC, 32'hD, 32'hF, 32'hE, 32'hA, 32'hB, 32'h9, 32'h8};

    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 17; k++) cycle(0, 1, 1, 0, 0, 1, tab[k % 16]);

    cycle(0, 0, 0, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 32'h0);
    cycle(0, 1, 0, 0, 0, 1, 32'h8);
    cycle(0, 1, 0, 0, 0, 1, 32'h9);

    cycle(0, 1, 1, 1, 32'hA, 1, 32'hF);
    cycle(1, 1, 1, 1, 32'hA, 1, 32'h0);

    cycle(0, 0, 0, 1, 32'hF, 0, 0);
    for (int k = 0; k < 3; k++)  cycle(0, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cycle(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)  cycle(0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 10000; k++) begin
      logic r, l, e, d;
      r = ($urandom_range(63) == 0);
      l = ($urandom_range(15) == 0);
      e = ($urandom_range(3) != 0);
      d = 1'($urandom_range(1));
      cycle(r, e, d, l, $urandom, 0, 0);
    end

    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 1, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #3;
    chk("scoreboard drained", 32'(sq.size() + nq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
